// File: rtl/mult_share_arb.sv
// mult_share_arb: two requesters share one 4x4 unsigned array multiplier.
// Round-robin arbitration, valid/ready on both sides, registered tagged result.
// Optional grant statistics counters enabled by macro MULT_ARB_STATS_EN.
module mult_share_arb #(
  parameter int unsigned W   = 4,
  parameter int unsigned LAT = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  input  logic [W-1:0]   req0_x,
  input  logic [W-1:0]   req0_y,
  output logic           req0_ready,
  input  logic           req1_valid,
  input  logic [W-1:0]   req1_x,
  input  logic [W-1:0]   req1_y,
  output logic           req1_ready,
  output logic           res_valid,
  output logic [2*W-1:0] res_z,
  output logic           res_id,
  input  logic           res_ready,
`ifdef MULT_ARB_STATS_EN
  output logic [7:0]     gnt_cnt0,
  output logic [7:0]     gnt_cnt1,
`endif
  output logic           busy
);

  localparam int unsigned PW   = 2 * W;
  localparam int unsigned CntW = 3;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    x_q, x_d, y_q, y_d;
  logic            id_q, id_d;
  // 1: req1 wins a tie (req0 was granted last)
  logic            rr_q, rr_d;
  logic            res_valid_q, res_valid_d;
  logic [PW-1:0]   res_z_q, res_z_d;
  logic            res_id_q, res_id_d;
  logic [PW-1:0]   prod;
  logic            gnt0, gnt1;

  // Array multiplier: sum of shifted partial products from the captured operands only
  always_comb begin
    prod = '0;
    for (int i = 0; i < W; i++) begin
      if (y_q[i]) prod = prod + (PW'(x_q) << i);
    end
  end

  // Round-robin grant, only offered while idle
  always_comb begin
    gnt0 = (state_q == StIdle) && req0_valid && (!req1_valid || !rr_q);
    gnt1 = (state_q == StIdle) && req1_valid && (!req0_valid || rr_q);
  end

  // Next-state and datapath register updates
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    id_d        = id_q;
    rr_d        = rr_q;
    res_valid_d = res_valid_q;
    res_z_d     = res_z_q;
    res_id_d    = res_id_q;
    unique case (state_q)
      StIdle: begin
        if (gnt0 || gnt1) begin
          x_d     = gnt1 ? req1_x : req0_x;
          y_d     = gnt1 ? req1_y : req0_y;
          id_d    = gnt1;
          rr_d    = gnt0;
          cnt_d   = CntW'(LAT - 1);
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (cnt_q == '0) begin
          res_z_d     = prod;
          res_id_d    = id_q;
          res_valid_d = 1'b1;
          state_d     = StDone;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      id_q        <= 1'b0;
      rr_q        <= 1'b0;
      res_valid_q <= 1'b0;
      res_z_q     <= '0;
      res_id_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      id_q        <= id_d;
      rr_q        <= rr_d;
      res_valid_q <= res_valid_d;
      res_z_q     <= res_z_d;
      res_id_q    <= res_id_d;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign res_valid  = res_valid_q;
  assign res_z      = res_z_q;
  assign res_id     = res_id_q;
  assign busy       = (state_q != StIdle);

`ifdef MULT_ARB_STATS_EN
  logic [7:0] gnt_cnt0_q, gnt_cnt0_d, gnt_cnt1_q, gnt_cnt1_d;

  // Saturating per-requester grant counters
  always_comb begin
    gnt_cnt0_d = gnt_cnt0_q;
    gnt_cnt1_d = gnt_cnt1_q;
    if (gnt0 && (gnt_cnt0_q != 8'hFF)) gnt_cnt0_d = gnt_cnt0_q + 8'd1;
    if (gnt1 && (gnt_cnt1_q != 8'hFF)) gnt_cnt1_d = gnt_cnt1_q + 8'd1;
  end

  // Grant counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cnt0_q <= '0;
      gnt_cnt1_q <= '0;
    end else begin
      gnt_cnt0_q <= gnt_cnt0_d;
      gnt_cnt1_q <= gnt_cnt1_d;
    end
  end

  assign gnt_cnt0 = gnt_cnt0_q;
  assign gnt_cnt1 = gnt_cnt1_q;
`endif

endmodule

// File: tb/tb_mult_share_arb.sv
// Self-checking bench for mult_share_arb: directed scenarios plus random traffic,
// checked every cycle against a transaction-level reference model.
module tb_mult_share_arb;
  localparam int unsigned LAT = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0, res_ready = 1'b0;
  logic [3:0] req0_x = '0, req0_y = '0, req1_x = '0, req1_y = '0;
  logic       req0_ready, req1_ready, res_valid, res_id, busy;
  logic [7:0] res_z;
`ifdef MULT_ARB_STATS_EN
  logic [7:0] gnt_cnt0, gnt_cnt1;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model: one outstanding job, result due LAT edges after accept
  bit m_busy, m_prio1;
  int n, m_due, m_z, m_id, m_c0, m_c1;

  always #5 clk = ~clk;

  mult_share_arb #(.W(4), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_x(req0_x), .req0_y(req0_y), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_x(req1_x), .req1_y(req1_y), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_z(res_z), .res_id(res_id), .res_ready(res_ready),
`ifdef MULT_ARB_STATS_EN
    .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1),
`endif
    .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model
  task automatic step(input bit v0, input logic [3:0] x0, input logic [3:0] y0,
                      input bit v1, input logic [3:0] x1, input logic [3:0] y1,
                      input bit rr);
    bit e0, e1, erv;
    @(negedge clk);
    req0_valid = v0; req0_x = x0; req0_y = y0;
    req1_valid = v1; req1_x = x1; req1_y = y1;
    res_ready = rr;
    #1;
    e0  = !m_busy && v0 && (!v1 || !m_prio1);
    e1  = !m_busy && v1 && (!v0 || m_prio1);
    erv = m_busy && (n >= m_due);
    check("req0_ready", 32'(req0_ready), 32'(e0));
    check("req1_ready", 32'(req1_ready), 32'(e1));
    check("busy", 32'(busy), 32'(m_busy));
    check("res_valid", 32'(res_valid), 32'(erv));
    if (erv) begin
      check("res_z", 32'(res_z), m_z);
      check("res_id", 32'(res_id), m_id);
    end
`ifdef MULT_ARB_STATS_EN
    check("gnt_cnt0", 32'(gnt_cnt0), m_c0);
    check("gnt_cnt1", 32'(gnt_cnt1), m_c1);
`endif
    @(posedge clk);
    n++;
    if (e0 || e1) begin
      m_busy  = 1'b1;
      m_prio1 = e0;
      m_due   = n + LAT;
      m_z     = e0 ? int'(x0) * int'(y0) : int'(x1) * int'(y1);
      m_id    = e0 ? 0 : 1;
      if (e0 && m_c0 < 255) m_c0++;
      if (e1 && m_c1 < 255) m_c1++;
    end
    if (erv && rr) m_busy = 1'b0;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge
  task automatic do_reset();
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_res_z", 32'(res_z), 0);
    check("rst_res_id", 32'(res_id), 0);
`ifdef MULT_ARB_STATS_EN
    check("rst_gnt_cnt0", 32'(gnt_cnt0), 0);
    check("rst_gnt_cnt1", 32'(gnt_cnt1), 0);
`endif
    m_busy = 1'b0; m_prio1 = 1'b0; n = 0; m_due = 0; m_c0 = 0; m_c1 = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();

    // Single requester 3*3
    for (int i = 0; i < LAT + 3; i++) step(1, 4'd3, 4'd3, 0, 4'd0, 4'd0, 1);
    step(0, 4'd0, 4'd0, 0, 4'd0, 4'd0, 1);

    // Tie from reset: 7*7 for req0 first, then 15*15 for req1
    do_reset();
    for (int i = 0; i < 2 * (LAT + 2) + 1; i++) step(1, 4'd7, 4'd7, 1, 4'd15, 4'd15, 1);

    // Result held while consumer stalls
    do_reset();
    step(1, 4'd5, 4'd6, 0, 4'd0, 4'd0, 0);
    for (int i = 0; i < LAT + 5; i++) step(1, 4'd1, 4'd1, 1, 4'd2, 4'd2, 0);
    step(0, 4'd0, 4'd0, 0, 4'd0, 4'd0, 1);

    // Continuous contention alternates owners at the minimum period
    do_reset();
    for (int i = 0; i < 4 * (LAT + 2); i++) step(1, 4'(i), 4'd9, 1, 4'd11, 4'(i), 1);

    // Reset while busy, then a fresh job returns with id 0
    do_reset();
    step(1, 4'd6, 4'd6, 0, 4'd0, 4'd0, 1);
    step(0, 4'd0, 4'd0, 0, 4'd0, 4'd0, 1);
    do_reset();
    for (int i = 0; i < LAT + 3; i++) step(1, 4'd2, 4'd3, 0, 4'd0, 4'd0, 1);

    // Random traffic including consumer back-pressure
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) < 60), 4'($urandom), 4'($urandom),
           ($urandom_range(0, 99) < 60), 4'($urandom), 4'($urandom),
           ($urandom_range(0, 99) < 70));
    end

`ifdef MULT_ARB_STATS_EN
    // Counter saturation: 300 req0 grants, 3 req1 grants
    do_reset();
    for (int i = 0; i < 300 * (LAT + 2); i++) step(1, 4'd1, 4'd2, 0, 4'd0, 4'd0, 1);
    for (int i = 0; i < 3 * (LAT + 2); i++) step(0, 4'd0, 4'd0, 1, 4'd3, 4'd4, 1);
    step(0, 4'd0, 4'd0, 0, 4'd0, 4'd0, 1);
    check("gnt_cnt0_sat", 32'(gnt_cnt0), 255);
    check("gnt_cnt1_final", 32'(gnt_cnt1), 3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
